// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus definitions: subcycle states, phase bit positions and helpers.
package mcs4_pkg;

    localparam int unsigned NumSubcycles = 8;

    // Bit positions of each subcycle inside the one-hot phase vector.
    localparam int unsigned PhaseA1 = 0;
    localparam int unsigned PhaseA2 = 1;
    localparam int unsigned PhaseA3 = 2;
    localparam int unsigned PhaseM1 = 3;
    localparam int unsigned PhaseM2 = 4;
    localparam int unsigned PhaseX1 = 5;
    localparam int unsigned PhaseX2 = 6;
    localparam int unsigned PhaseX3 = 7;

    typedef enum logic [3:0] {
        StUnsync = 4'd0,
        StA1     = 4'd1,
        StA2     = 4'd2,
        StA3     = 4'd3,
        StM1     = 4'd4,
        StM2     = 4'd5,
        StX1     = 4'd6,
        StX2     = 4'd7,
        StX3     = 4'd8
    } seq_state_e;

    // One-hot phase vector for a state; all zero while unsynchronised.
    function automatic logic [NumSubcycles-1:0] phase_onehot(input seq_state_e st);
        logic [NumSubcycles-1:0] oh;
        oh = '0;
        case (st)
            StA1:    oh[PhaseA1] = 1'b1;
            StA2:    oh[PhaseA2] = 1'b1;
            StA3:    oh[PhaseA3] = 1'b1;
            StM1:    oh[PhaseM1] = 1'b1;
            StM2:    oh[PhaseM2] = 1'b1;
            StX1:    oh[PhaseX1] = 1'b1;
            StX2:    oh[PhaseX2] = 1'b1;
            StX3:    oh[PhaseX3] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    // Successor in the A1..X3 ring without SYNC; X3 and UNSYNC fall out to UNSYNC.
    function automatic seq_state_e next_subcycle(input seq_state_e st);
        seq_state_e nx;
        case (st)
            StA1:    nx = StA2;
            StA2:    nx = StA3;
            StA3:    nx = StM1;
            StM1:    nx = StM2;
            StM2:    nx = StX1;
            StX1:    nx = StX2;
            StX2:    nx = StX3;
            default: nx = StUnsync;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/mcs4_edge_det.sv
// Falling-edge detector: pulses for the clk in which sig goes from 1 to 0.
module mcs4_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic fall
);

    logic sig_prev;

    // One-clk history of the input level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig;
        end
    end

    assign fall = sig_prev & ~sig;

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// Tracks the 4004 eight-subcycle bus cycle from PHI2/SYNC and captures address and opcode.
module mcs4_bus_sequencer
    import mcs4_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned LOCK_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 PHI1_i,
    input  logic                 PHI2_i,
    input  logic                 SYNC_i,
    input  logic [3:0]           D_i,
    output logic [7:0]           phase_o,
    output logic [11:0]          addr_o,
    output logic [7:0]           opcode_o,
    output logic                 instr_valid_o,
    output logic                 locked_o,
    output logic                 sync_err_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

    localparam int unsigned LockW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [LockW-1:0] LockTarget = LockW'(LOCK_CYCLES);

    seq_state_e       state;
    seq_state_e       state_next;
    logic             advance;
    logic             framing;
    logic             err_next;
    logic             well_formed;
    logic             x3_exit;
    logic             complete;
    logic [11:0]      stage_addr;
    logic [3:0]       stage_opr;
    logic [LockW-1:0] lock_cnt;
    logic [LockW-1:0] lock_inc;

    mcs4_edge_det u_phi2_fall (
        .clk  (clk_i),
        .rst  (rst_i),
        .sig  (PHI2_i),
        .fall (advance)
    );

    // PHI1 and PHI2 high together means the clock generator is broken.
    assign framing = PHI1_i & PHI2_i;

    // Subcycle state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= StUnsync;
        end else begin
            state <= state_next;
        end
    end

    // Next subcycle and per-event decodes; error paths pre-empt instruction completion.
    always_comb begin
        state_next  = state;
        err_next    = 1'b0;
        well_formed = 1'b0;
        x3_exit     = 1'b0;
        complete    = 1'b0;
        if (framing) begin
            state_next = StUnsync;
            err_next   = 1'b1;
        end else if (advance) begin
            x3_exit = (state == StX3);
            if (SYNC_i) begin
                state_next = StA1;
                if (state == StX3) begin
                    well_formed = 1'b1;
                end else if (state != StUnsync) begin
                    err_next = 1'b1;
                end
            end else if (state == StX3) begin
                state_next = StUnsync;
                err_next   = 1'b1;
            end else begin
                state_next = next_subcycle(state);
                complete   = (state == StM2);
            end
        end
    end

    assign phase_o  = phase_onehot(state);
    assign lock_inc = (lock_cnt == LockTarget) ? lock_cnt : lock_cnt + LockW'(1);

    // Stage nibbles as each subcycle is left; outputs only move when a full fetch lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_addr    <= 12'h000;
            stage_opr     <= 4'h0;
            addr_o        <= 12'h000;
            opcode_o      <= 8'h00;
            instr_valid_o <= 1'b0;
        end else begin
            instr_valid_o <= complete;
            if (advance) begin
                case (state)
                    StA1:    stage_addr[3:0]  <= D_i;
                    StA2:    stage_addr[7:4]  <= D_i;
                    StA3:    stage_addr[11:8] <= D_i;
                    StM1:    stage_opr        <= D_i;
                    default: ;
                endcase
            end
            if (complete) begin
                addr_o   <= stage_addr;
                opcode_o <= {stage_opr, D_i};
            end
        end
    end

    // Lock tracking, error pulse and completed-cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_cnt    <= '0;
            locked_o    <= 1'b0;
            sync_err_o  <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            sync_err_o <= err_next;
            if (err_next) begin
                lock_cnt <= '0;
                locked_o <= 1'b0;
            end else if (well_formed) begin
                lock_cnt <= lock_inc;
                if (lock_inc == LockTarget) begin
                    locked_o <= 1'b1;
                end
            end
            if (x3_exit) begin
                cycle_cnt_o <= cycle_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Directed bench for mcs4_bus_sequencer with a subcycle-position model checked every clk.
module tb_mcs4_bus_sequencer;

    localparam int LockCycles = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic phi1 = 1'b0;
    logic phi2 = 1'b0;
    logic sync = 1'b0;
    logic [3:0] d = 4'h0;

    logic [7:0]  phase;
    logic [11:0] addr;
    logic [7:0]  opcode;
    logic        instr_valid;
    logic        locked;
    logic        sync_err;
    logic [15:0] cnt;

    logic [7:0]  phase4;
    logic [11:0] addr4;
    logic [7:0]  opcode4;
    logic        instr_valid4;
    logic        locked4;
    logic        sync_err4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;

    mcs4_bus_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .PHI1_i        (phi1),
        .PHI2_i        (phi2),
        .SYNC_i        (sync),
        .D_i           (d),
        .phase_o       (phase),
        .addr_o        (addr),
        .opcode_o      (opcode),
        .instr_valid_o (instr_valid),
        .locked_o      (locked),
        .sync_err_o    (sync_err),
        .cycle_cnt_o   (cnt)
    );

    mcs4_bus_sequencer #(.CNT_WIDTH(4)) dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .PHI1_i        (phi1),
        .PHI2_i        (phi2),
        .SYNC_i        (sync),
        .D_i           (d),
        .phase_o       (phase4),
        .addr_o        (addr4),
        .opcode_o      (opcode4),
        .instr_valid_o (instr_valid4),
        .locked_o      (locked4),
        .sync_err_o    (sync_err4),
        .cycle_cnt_o   (cnt4)
    );

    always #5 clk = ~clk;

    // Model: position in the cycle (-1 = lost, 0..7 = A1..X3) plus captured nibbles.
    int          m_pos;
    bit          m_prev;
    logic [3:0]  m_nib [0:3];
    logic [11:0] m_addr;
    logic [7:0]  m_op;
    bit          m_valid;
    bit          m_err;
    bit          m_locked;
    int          m_good;
    int unsigned m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos    <= -1;
            m_prev   <= 1'b0;
            m_addr   <= '0;
            m_op     <= '0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
            m_locked <= 1'b0;
            m_good   <= 0;
            m_cnt    <= 0;
        end else begin : model_step
            int p;
            int g;
            bit lk;
            bit e;
            bit v;
            p  = m_pos;
            g  = m_good;
            lk = m_locked;
            e  = 1'b0;
            v  = 1'b0;
            if (phi1 && phi2) begin
                p = -1; e = 1'b1; g = 0; lk = 1'b0;
            end else if (m_prev && !phi2) begin
                if (p >= 0 && p <= 3) m_nib[p] <= d;
                if (p == 7) m_cnt <= m_cnt + 1;
                if (sync) begin
                    if (p == 7) begin
                        if (g < LockCycles) g = g + 1;
                        if (g >= LockCycles) lk = 1'b1;
                    end else if (p >= 0) begin
                        e = 1'b1; g = 0; lk = 1'b0;
                    end
                    p = 0;
                end else if (p == 7) begin
                    p = -1; e = 1'b1; g = 0; lk = 1'b0;
                end else if (p == 4) begin
                    m_addr <= {m_nib[2], m_nib[1], m_nib[0]};
                    m_op   <= {m_nib[3], d};
                    v = 1'b1;
                    p = 5;
                end else if (p >= 0) begin
                    p = p + 1;
                end
            end
            m_pos    <= p;
            m_good   <= g;
            m_locked <= lk;
            m_err    <= e;
            m_valid  <= v;
            m_prev   <= phi2;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-clk comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("outputs", {phase, addr, opcode, instr_valid, locked, sync_err, cnt, cnt4},
                  {((m_pos < 0) ? 8'h00 : (8'h01 << m_pos)), m_addr, m_op, m_valid,
                   m_locked, m_err, m_cnt[15:0], m_cnt[3:0]});
            if (instr_valid) n_valid++;
        end
    end

    // One subcycle of the clock generator: PHI1, gap, PHI2, gap; PHI2 falls into the gap.
    task automatic subcycle(input logic s, input logic [3:0] nib);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            phi1 = (k == 0);
            phi2 = (k == 2);
            sync = s;
            d    = nib;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Full A1..X3 pass starting in A1; SYNC during X3 chooses a clean or broken restart.
    task automatic run_cycle(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2,
                             input logic [3:0] n3, input logic [3:0] n4, input logic s_end);
        subcycle(1'b0, n0);
        subcycle(1'b0, n1);
        subcycle(1'b0, n2);
        subcycle(1'b0, n3);
        subcycle(1'b0, n4);
        subcycle(1'b0, 4'h0);
        subcycle(1'b0, 4'h0);
        subcycle(s_end, 4'h0);
    endtask

    task automatic check_zero(input string name);
        check(name, {phase, addr, opcode, instr_valid, locked, sync_err, cnt, cnt4}, 64'h0);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // Acquire: first SYNC from UNSYNC lands in A1.
        subcycle(1'b1, 4'h0);
        settle();
        check("first_sync_phase", phase, 8'h01);

        run_cycle(4'h3, 4'h2, 4'h1, 4'hD, 4'h4, 1'b1);
        settle();
        check("c1_addr", addr, 12'h123);
        check("c1_opcode", opcode, 8'hD4);
        check("c1_valid_pulses", n_valid, 1);
        check("c1_not_locked", locked, 1'b0);

        run_cycle(4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 1'b1);
        settle();
        check("c2_locked", locked, 1'b1);
        check("c2_cnt", cnt, 16'd2);
        check("c2_instr", {addr, opcode}, {12'h765, 8'h89});

        // SYNC at M1 exit aborts the fetch.
        subcycle(1'b0, 4'h1);
        subcycle(1'b0, 4'h2);
        subcycle(1'b0, 4'h3);
        subcycle(1'b1, 4'h4);
        settle();
        check("abort_phase", phase, 8'h01);
        check("abort_err", sync_err, 1'b1);
        check("abort_unlocked", locked, 1'b0);
        check("abort_no_valid", n_valid, 2);

        // Missing SYNC at X3 exit drops to UNSYNC but still counts the cycle.
        run_cycle(4'hA, 4'hB, 4'hC, 4'h5, 4'h6, 1'b0);
        settle();
        check("nosync_phase", phase, 8'h00);
        check("nosync_err", sync_err, 1'b1);
        check("nosync_cnt", cnt, 16'd3);
        check("nosync_instr", {addr, opcode}, {12'hCBA, 8'h56});

        // Reset asserted in the middle of A3.
        subcycle(1'b1, 4'h0);
        subcycle(1'b0, 4'h1);
        subcycle(1'b0, 4'h2);
        @(negedge clk);
        phi1 = 1'b1; phi2 = 1'b0; sync = 1'b0; d = 4'h3;
        @(negedge clk);
        phi1 = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; phi1 = 1'b0; phi2 = 1'b0; sync = 1'b0;
        v0 = n_valid;
        subcycle(1'b0, 4'hF);
        subcycle(1'b0, 4'hF);
        subcycle(1'b0, 4'hF);
        settle();
        check("post_reset_unsync", phase, 8'h00);
        check("post_reset_no_valid", n_valid, v0);

        subcycle(1'b1, 4'h0);
        run_cycle(4'h7, 4'h8, 4'h9, 4'hE, 4'hF, 1'b1);
        settle();
        check("c4_instr", {addr, opcode}, {12'h987, 8'hEF});
        check("c4_valid", n_valid, v0 + 1);
        check("c4_cnt", cnt, 16'd1);

        // Sixteen more clean cycles: seventeen X3 exits since reset.
        for (int i = 0; i < 16; i++) begin
            run_cycle(4'(i), 4'h1, 4'h2, 4'h3, 4'(15 - i), 1'b1);
        end
        settle();
        check("cnt16_17", cnt, 16'd17);
        check("cnt4_wrap", cnt4, 4'h1);
        check("long_locked", locked, 1'b1);

        // PHI1 and PHI2 high together is a framing violation.
        @(negedge clk);
        phi1 = 1'b1; phi2 = 1'b1; sync = 1'b0;
        settle();
        check("framing_phase", phase, 8'h00);
        check("framing_err", sync_err, 1'b1);
        check("framing_unlocked", locked, 1'b0);
        @(negedge clk);
        phi1 = 1'b0; phi2 = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
